cubic_poly_arb: RTL

Round-robin arbiter that shares one cubic_poly datapath among NUM_REQ requesters.
- Accepts operand pairs (x, k) from requesters and issues at most one per cycle into the unit.
- Tracks each in-flight op's requester ID through a tag pipeline matched to the unit's fixed latency.
- Steers each returned cube result back to the requester that issued it.

---
 rtl/cubic_poly_arb.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/cubic_poly_arb.sv
// cubic_poly_arb: round-robin arbiter sharing one cubic_poly unit among
// NUM_REQ requesters. Operands are issued through registered pu_* outputs,
// and a tag pipe tracks each op's owner until the unit's result returns.
// Optional feature macro: CUBIC_ARB_STATS_EN (saturating per-requester grant
// counters on stat_gnt_cnt; tied to zero when undefined).
module cubic_poly_arb #(
  parameter int NUM_REQ  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   err_clr,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   x_req,
  input  logic [3*NUM_REQ-1:0]   k_req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [8:0]             rsp_cube,
  output logic [2:0]             pu_x_in,
  output logic [2:0]             pu_k_in,
  output logic                   pu_issue,
  input  logic [8:0]             pu_cube,
  input  logic                   pu_valid_out,
  output logic                   idle,
  output logic                   err,
  output logic [8*NUM_REQ-1:0]   stat_gnt_cnt
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   busy_q, busy_d;
  logic [2:0]           pu_x_q, pu_k_q;
  logic                 pu_issue_q;
  logic [IDW-1:0]       issue_id_q;
  logic [PIPE_LAT-1:0]  tag_v_q;
  logic [IDW-1:0]       tag_id_q [PIPE_LAT];
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   gnt_s;
  logic [IDW-1:0]       win_s;
  logic                 any_gnt_s;
  logic [2:0]           x_sel_s, k_sel_s;
  logic                 ev_s;
  logic [IDW-1:0]       eid_s;
  logic                 rsp_hit_s;
  logic                 in_flight_s;
  logic [NUM_REQ-1:0]   rsp_valid_s;
  logic [8:0]           rsp_cube_s;

  // The issue register counts as the first slot of the op's latency, so the
  // final tag stage lines up with pu_valid_out PIPE_LAT cycles after pu_issue.
  assign ev_s        = tag_v_q[PIPE_LAT-1];
  assign eid_s       = tag_id_q[PIPE_LAT-1];
  assign rsp_hit_s   = ev_s & pu_valid_out;
  assign in_flight_s = pu_issue_q | (|tag_v_q);

  // Round-robin search from the pointer; grants only while running and enabled.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_s     = '0;
    win_s     = '0;
    any_gnt_s = 1'b0;
    if ((state_q == ST_RUN) && en) begin
      for (int n = 0; n < NUM_REQ; n++) begin
        idx = (int'(ptr_q) + n) % NUM_REQ;
        if (!any_gnt_s && req[idx] && !busy_q[idx]) begin
          any_gnt_s = 1'b1;
          win_s     = IDW'(idx);
        end else begin
          any_gnt_s = any_gnt_s;
        end
      end
      gnt_s[win_s] = any_gnt_s;
    end else begin
      gnt_s = '0;
    end
  end

  // Operand select, pointer advance, busy bookkeeping and sticky error update.
  always_comb begin
    x_sel_s = x_req[int'(win_s)*3 +: 3];
    k_sel_s = k_req[int'(win_s)*3 +: 3];
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    if (any_gnt_s) begin
      if (int'(win_s) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + IDW'(1);
      end
      busy_d[win_s] = 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
    if (ev_s) begin
      busy_d[eid_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    err_d = (err_q & ~err_clr) | (ev_s ^ pu_valid_out);
  end

  // Steer a returned result to the requester that owns the final tag.
  always_comb begin
    rsp_valid_s = '0;
    rsp_cube_s  = 9'd0;
    if (rsp_hit_s) begin
      rsp_valid_s[eid_s] = 1'b1;
      rsp_cube_s         = pu_cube;
    end else begin
      rsp_valid_s = '0;
      rsp_cube_s  = 9'd0;
    end
  end

  // Control FSM with its registered issue outputs, tag pipe and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      busy_q     <= '0;
      pu_x_q     <= 3'd0;
      pu_k_q     <= 3'd0;
      pu_issue_q <= 1'b0;
      issue_id_q <= '0;
      tag_v_q    <= '0;
      for (int s = 0; s < PIPE_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= en ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (en) begin
            state_q <= ST_RUN;
          end else if (in_flight_s) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: state_q <= in_flight_s ? ST_DRAIN : ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      pu_issue_q <= any_gnt_s;
      pu_x_q     <= any_gnt_s ? x_sel_s : 3'd0;
      pu_k_q     <= any_gnt_s ? k_sel_s : 3'd0;
      issue_id_q <= any_gnt_s ? win_s : '0;
      tag_v_q[0]  <= pu_issue_q;
      tag_id_q[0] <= issue_id_q;
      for (int s = 1; s < PIPE_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      err_q      <= err_d;
    end
  end

  assign gnt       = gnt_s;
  assign rsp_valid = rsp_valid_s;
  assign rsp_cube  = rsp_cube_s;
  assign pu_x_in   = pu_x_q;
  assign pu_k_in   = pu_k_q;
  assign pu_issue  = pu_issue_q;
  assign err       = err_q;
  assign idle      = (state_q == ST_IDLE) && !in_flight_s;

`ifdef CUBIC_ARB_STATS_EN
  logic [7:0] cnt_q [NUM_REQ];

  // Saturating per-requester grant counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_s[i] && (cnt_q[i] != 8'd255)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end else begin
          cnt_q[i] <= cnt_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_gnt_cnt[8*g +: 8] = cnt_q[g];
  end
`else
  assign stat_gnt_cnt = '0;
`endif

endmodule
